// File: rtl/router_input_scheduler.sv
// Round-robin wormhole scheduler for the shared routing stage.
// Owner keeps the stage until its tail flit transfers.
module router_input_scheduler #(
  parameter int NREQ    = 5,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_last,
  input  logic            out_ready,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid,
  output logic            out_valid,
  output logic [NREQ-1:0] shift,
  output logic [CNTW-1:0] pkt_count,
  output logic            stall_err
);

  localparam int SCW = $clog2(TIMEOUT + 1);
  localparam int W1  = IDW + 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [SCW-1:0] TMO     = SCW'(TIMEOUT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [IDW-1:0]  id_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [IDW-1:0]  nxt_id;
  logic [CNTW-1:0] pkt_n;
  logic [SCW-1:0]  stall_cnt, stall_n;
  logic            err_n;

  logic [IDW-1:0]  start;
  logic [W1-1:0]   sum;
  logic [IDW-1:0]  idx;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] win_oh;

  logic            is_tail;
  logic            xfer;

  assign grant_valid = |grant;
  assign out_valid   = |(grant & req);
  assign is_tail     = |(grant & req_last);
  assign xfer        = out_valid & out_ready;
  assign shift       = grant & {NREQ{xfer}};

  assign nxt_id = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // Search start: ptr when idle, one past the owner when re-arbitrating.
  always_comb begin
    start = ptr;
    if (state == BUSY) start = nxt_id;
  end

  // First requester found scanning from start with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, start} + W1'(k);
      if (sum >= W1'(NREQ)) sum = sum - W1'(NREQ);
      idx = sum[IDW-1:0];
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
        win_oh    = NREQ'(1) << idx;
      end
    end
  end

  // Next-state, grant, packet counter and watchdog update.
  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n    = grant_id;
    ptr_n   = ptr;
    pkt_n   = pkt_count;
    stall_n = stall_cnt;
    err_n   = stall_err;
    unique case (state)
      IDLE: begin
        stall_n = '0;
        if (win_found) begin
          grant_n = win_oh;
          id_n    = win_id;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          stall_n = '0;
          if (is_tail) begin
            pkt_n = pkt_count + 1'b1;
            ptr_n = nxt_id;
            if (win_found) begin
              grant_n = win_oh;
              id_n    = win_id;
            end else begin
              grant_n = '0;
              id_n    = '0;
              state_n = IDLE;
            end
          end
        end else if (stall_cnt != TMO) begin
          stall_n = stall_cnt + 1'b1;
          if (stall_n == TMO) err_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        id_n    = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_id  <= '0;
      ptr       <= '0;
      pkt_count <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_id  <= id_n;
      ptr       <= ptr_n;
      pkt_count <= pkt_n;
      stall_cnt <= stall_n;
      stall_err <= err_n;
    end
  end

endmodule

// File: tb/tb_router_input_scheduler.sv
// Directed bench for router_input_scheduler.
// Inputs change 1ns after the rising edge; outputs checked then.
module tb_router_input_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] req_last;
  logic       out_ready;
  logic [4:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       out_valid;
  logic [4:0] shift;
  logic [15:0] pkt_count;
  logic       stall_err;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  router_input_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_last   (req_last),
    .out_ready  (out_ready),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .out_valid  (out_valid),
    .shift      (shift),
    .pkt_count  (pkt_count),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_last = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 5'b00000);
    chk("rst_id", grant_id, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_err", stall_err, 0);

    // rotation, all single-flit packets
    req = 5'b11111;
    req_last = 5'b11111;
    out_ready = 1'b1;
    tick();
    chk("rot_id0", grant_id, 0);
    chk("rot_shift0", shift, 5'b00001);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("rot_id", grant_id, k);
      chk("rot_pkt", pkt_count, k);
    end
    tick();
    chk("rot_wrap_id", grant_id, 0);
    chk("rot_pkt5", pkt_count, 5);

    // async reset while busy
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_shift", shift, 0);
    chk("arst_pkt", pkt_count, 0);
    chk("arst_err", stall_err, 0);
    tick();
    rst = 1'b0;
    req = '0;
    req_last = '0;
    #1;

    // lock: q2 4-flit packet while q0 requests
    req = 5'b00100;
    tick();
    chk("lock_grant2", grant_id, 2);
    req = 5'b00101;
    pops = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_last = 5'b00100;
      #1;
      chk("lock_id", grant_id, 2);
      if (shift == 5'b00100) pops++;
      tick();
    end
    chk("lock_pops", pops, 4);
    chk("lock_next_id", grant_id, 0);
    chk("lock_pkt", pkt_count, 1);

    // backpressure: q0 single flit, then q1 owns under out_ready=0
    req = 5'b00011;
    req_last = 5'b00001;
    tick();
    chk("bp_owner", grant_id, 1);
    out_ready = 1'b0;
    req_last = 5'b00000;
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (shift != 0) pops++;
      tick();
      chk("bp_hold", grant_id, 1);
    end
    chk("bp_noshift", pops, 0);
    out_ready = 1'b1;
    req_last = 5'b00010;
    #1;
    chk("bp_resume", shift, 5'b00010);
    tick();
    chk("bp_pkt", pkt_count, 3);
    chk("bp_next", grant_id, 0);
    chk("bp_err", stall_err, 0);

    // watchdog: owner q0 loses its request
    req = 5'b00000;
    req_last = 5'b00000;
    for (int k = 0; k < 63; k++) tick();
    chk("wd_63", stall_err, 0);
    tick();
    chk("wd_64", stall_err, 1);
    req = 5'b00001;
    req_last = 5'b00001;
    tick();
    chk("wd_pkt", pkt_count, 4);
    chk("wd_sticky", stall_err, 1);
    tick();
    chk("wd_sticky2", stall_err, 1);

    // wrap/self: only q4 requesting
    rst = 1'b1;
    #1;
    chk("ws_rst_err", stall_err, 0);
    tick();
    rst = 1'b0;
    req = 5'b10000;
    req_last = 5'b10000;
    tick();
    chk("ws_id_a", grant_id, 4);
    chk("ws_shift_a", shift, 5'b10000);
    tick();
    chk("ws_id_b", grant_id, 4);
    chk("ws_shift_b", shift, 5'b10000);
    chk("ws_pkt1", pkt_count, 1);
    req = 5'b10001;
    req_last = 5'b11111;
    tick();
    chk("ws_pkt2", pkt_count, 2);
    chk("ws_ptr_wrap", grant_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
